// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: field widths, opcodes,
// accumulator source encodings and the fetch/decode state type.
package bip_pkg;

  localparam int PC_WIDTH      = 11;
  localparam int INSTR_WIDTH   = 16;
  localparam int OPCODE_WIDTH  = 5;
  localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;
  localparam int CNT_WIDTH     = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    HALT   = 2'd2
  } state_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder; every output is zero unless en is high,
// so the caller only has to qualify it with the DECODE state.
module bip_decoder
  import bip_pkg::*;
(
  input  logic                    en,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [1:0]              sel_a,
  output logic                    sel_b,
  output logic                    alu_op,
  output logic                    wr_acc,
  output logic                    wr_ram,
  output logic                    rd_ram,
  output logic                    illegal,
  output logic                    is_halt
);

  always_comb begin
    sel_a   = SEL_A_MEM;
    sel_b   = 1'b0;
    alu_op  = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    illegal = 1'b0;
    is_halt = 1'b0;
    if (en) begin
      case (opcode)
        OP_HLT:  is_halt = 1'b1;
        OP_STO:  wr_ram  = 1'b1;
        OP_LD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
        end
        OP_LDI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_IMM;
        end
        OP_ADD, OP_SUB: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          alu_op = (opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b1;
          alu_op = (opcode == OP_SUBI);
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: two-cycle fetch/decode sequencer with program counter,
// halt state and a saturating count of active (non-halted) clocks.
module bip_control
  import bip_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_WIDTH-1:0]   instr_data,
  output logic [PC_WIDTH-1:0]      pc_addr,
  output logic [OPERAND_WIDTH-1:0] operand,
  output logic [1:0]               sel_a,
  output logic                     sel_b,
  output logic                     alu_op,
  output logic                     wr_acc,
  output logic                     wr_ram,
  output logic                     rd_ram,
  output logic                     halted,
  output logic                     illegal_op,
  output logic [CNT_WIDTH-1:0]     cycle_count
);

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0] operand_q, operand_d;
  logic                     dec_en;
  logic                     dec_halt;

  assign dec_en = (state_q == DECODE);

  bip_decoder u_decoder (
    .en      (dec_en),
    .opcode  (instr_data[INSTR_WIDTH-1:OPERAND_WIDTH]),
    .sel_a   (sel_a),
    .sel_b   (sel_b),
    .alu_op  (alu_op),
    .wr_acc  (wr_acc),
    .wr_ram  (wr_ram),
    .rd_ram  (rd_ram),
    .illegal (illegal_op),
    .is_halt (dec_halt)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        operand_d = instr_data[OPERAND_WIDTH-1:0];
        if (dec_halt) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          pc_d    = pc_q + PC_WIDTH'(1);
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // The HLT decode cycle itself still counts; only cycles spent halted do not.
    if ((state_q != HALT) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      cnt_q     <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
    end
  end

  assign pc_addr     = pc_q;
  assign operand     = dec_en ? instr_data[OPERAND_WIDTH-1:0] : operand_q;
  assign halted      = (state_q == HALT);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: directed programs plus randomized
// instruction streams compared against an instruction-level timing model.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr_data = 16'hFFFF;
  logic [10:0] pc_addr;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, wr_acc, wr_ram, rd_ram, halted, illegal_op;
  logic [15:0] cycle_count;
  logic [7:0]  obs_ctrl;

  logic [15:0] mem [2048];

  int pass_cnt = 0;
  int total_cnt = 0;

  int   m_k;
  logic m_halted;
  logic m_pend_halt;
  int   m_halt_pc;
  int   m_last_operand;

  bip_control dut (
    .clk         (clk),
    .rst         (rst),
    .instr_data  (instr_data),
    .pc_addr     (pc_addr),
    .operand     (operand),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .alu_op      (alu_op),
    .wr_acc      (wr_acc),
    .wr_ram      (wr_ram),
    .rd_ram      (rd_ram),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Program memory: one-cycle read latency, all-ones while held in reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) instr_data <= 16'hFFFF;
    else      instr_data <= mem[pc_addr];
  end

  assign obs_ctrl = {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, illegal_op};

  // Expected {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, illegal} per opcode.
  function automatic logic [7:0] expCtrl(input logic [4:0] op);
    case (op)
      5'd0:    return 8'b00_0_0_0_0_0_0;
      5'd1:    return 8'b00_0_0_0_1_0_0;
      5'd2:    return 8'b00_0_0_1_0_1_0;
      5'd3:    return 8'b01_0_0_1_0_0_0;
      5'd4:    return 8'b10_0_0_1_0_1_0;
      5'd5:    return 8'b10_1_0_1_0_0_0;
      5'd6:    return 8'b10_0_1_1_0_1_0;
      5'd7:    return 8'b10_1_1_1_0_0_0;
      default: return 8'b00_0_0_0_0_0_1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Model: k = clocks taken since reset release while not halted; even k is a
  // fetch, odd k a decode, and instruction k/2 sits at address (k/2) mod 2048.
  task automatic checkOutput();
    int          exp_pc;
    logic        decode;
    logic [15:0] ins;
    if (m_halted) begin
      exp_pc = m_halt_pc;
      decode = 1'b0;
    end else begin
      exp_pc = (m_k / 2) % 2048;
      decode = (m_k % 2) == 1;
    end
    ins = mem[exp_pc];
    check("pc_addr", 32'(pc_addr), exp_pc);
    check("controls", 32'(obs_ctrl), decode ? 32'(expCtrl(ins[15:11])) : 32'd0);
    check("operand", 32'(operand), decode ? 32'(ins[10:0]) : m_last_operand);
    check("halted", 32'(halted), 32'(m_halted));
    check("cycle_count", 32'(cycle_count), (m_k > 65535) ? 65535 : m_k);
    if (decode) begin
      m_last_operand = int'(ins[10:0]);
      if (ins[15:11] == 5'd0) begin
        m_pend_halt = 1'b1;
        m_halt_pc   = exp_pc;
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!m_halted) m_k++;
      if (m_pend_halt) begin
        m_halted    = 1'b1;
        m_pend_halt = 1'b0;
      end
      @(negedge clk);
      checkOutput();
    end
  endtask

  task automatic modelReset();
    m_k            = 0;
    m_halted       = 1'b0;
    m_pend_halt    = 1'b0;
    m_halt_pc      = 0;
    m_last_operand = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput();
    rst = 1'b1;
  endtask

  task automatic fillRandom(input bit allow_halt);
    for (int i = 0; i < 2048; i++) begin
      mem[i] = {5'($urandom_range(allow_halt ? 0 : 1, 31)), 11'($urandom)};
    end
  endtask

  initial begin
    $display("[TB] starting bip_control bench");
    modelReset();

    // Directed program: LDI 4 / STO 1 / LDI 2 / LD 1 / ADD 1 / HLT
    fillRandom(1'b0);
    mem[0] = 16'h1804;
    mem[1] = 16'h0801;
    mem[2] = 16'h1802;
    mem[3] = 16'h1001;
    mem[4] = 16'h2001;
    mem[5] = 16'h0000;
    doReset();
    applyStimulus(16);
    check("prog_halted", 32'(halted), 32'd1);
    check("prog_count", 32'(cycle_count), 32'd12);
    check("prog_pc", 32'(pc_addr), 32'd5);

    // Random program with an all-ones word, SUBI 7, and a late HLT
    fillRandom(1'b0);
    mem[3]  = 16'hFFFF;
    mem[5]  = 16'h3807;
    mem[40] = 16'h0000;
    doReset();
    applyStimulus(11);
    check("subi_ctrl", 32'(obs_ctrl), 32'b10_1_1_1_0_0_0);
    check("subi_operand", 32'(operand), 32'd7);
    applyStimulus(85);
    check("rand_halted", 32'(halted), 32'd1);
    check("rand_count", 32'(cycle_count), 32'd82);

    // Asynchronous reset in the middle of an ADD decode cycle
    fillRandom(1'b0);
    mem[0] = 16'h2003;
    doReset();
    applyStimulus(1);
    check("add_wr_acc", 32'(wr_acc), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_wr_acc", 32'(wr_acc), 32'd0);
    check("async_pc", 32'(pc_addr), 32'd0);
    check("async_count", 32'(cycle_count), 32'd0);
    check("async_operand", 32'(operand), 32'd0);
    modelReset();
    @(negedge clk);
    checkOutput();
    rst = 1'b1;
    applyStimulus(6);

    // Long halt-free stream: PC wraps many times, counter must saturate
    fillRandom(1'b0);
    doReset();
    applyStimulus(4096);
    check("wrap_pc", 32'(pc_addr), 32'd0);
    applyStimulus(61450);
    check("sat_count", 32'(cycle_count), 32'hFFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit of the BIP processor, directly downstream of the program memory.
- Drives the instruction fetch address, captures the returned 16-bit instruction, and decodes it into datapath controls for the accumulator, ALU and data memory.
- Owns the program counter, halt state and a running cycle counter.

Parameters:
- PC_WIDTH, 11, program address width (2048 words).
- INSTR_WIDTH, 16, instruction width.
- OPCODE_WIDTH, 5, opcode field width; operand width is INSTR_WIDTH-OPCODE_WIDTH.
- CNT_WIDTH, 16, cycle counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_data  in  16  instruction from program memory; valid the cycle after the address is presented.
- pc_addr  out  11  program memory address.
- operand  out  11  instruction bits [10:0], used as data-memory address or immediate.
- sel_a  out  2  accumulator source: 0 data memory, 1 immediate, 2 ALU result.
- sel_b  out  1  ALU B operand: 0 data memory, 1 immediate.
- alu_op  out  1  0 add, 1 subtract.
- wr_acc  out  1  accumulator write enable.
- wr_ram  out  1  data-memory write enable (stores the accumulator).
- rd_ram  out  1  data-memory read enable.
- halted  out  1  high once HLT has executed.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- cycle_count  out  16  clocks spent in FETCH/DECODE since reset; saturating.

Behaviour:
- Reset (rst=0, async):
  - state=FETCH; pc_addr=0; cycle_count=0; halted=0.
  - All enables 0; sel_a=0, sel_b=0, alu_op=0; operand=0.
  - Reset takes effect immediately mid-instruction and discards any pending decode.
- State machine:
  - FETCH: pc_addr is stable and memory samples it at the next edge. Go to DECODE.
  - DECODE: instr_data is valid. Controls are decoded combinationally from instr_data and asserted for exactly this cycle. At the closing edge, pc_addr<=pc_addr+1 (wraps 2047->0) and state<=FETCH. HLT instead goes to HALT with PC unchanged.
  - HALT: terminal. All enables 0; pc_addr and cycle_count frozen. Only reset exits.
- Timing: 2 cycles per instruction. First decode occurs in the 2nd cycle after reset deassertion. Memory output produced while memory is itself in reset (0xFFFF) is never decoded, because the first DECODE follows a FETCH taken out of reset.
- Opcodes (bits [15:11]); all controls are 0 except those listed:
  - 00000 HLT: no controls; enter HALT.
  - 00001 STO: wr_ram=1.
  - 00010 LD: rd_ram=1, wr_acc=1, sel_a=0.
  - 00011 LDI: wr_acc=1, sel_a=1.
  - 00100 ADD: rd_ram=1, wr_acc=1, sel_a=2, sel_b=0, alu_op=0.
  - 00101 ADDI: wr_acc=1, sel_a=2, sel_b=1, alu_op=0.
  - 00110 SUB: as ADD with alu_op=1.
  - 00111 SUBI: as ADDI with alu_op=1.
  - Any other opcode (including 11111): no controls, illegal_op=1 for the DECODE cycle, PC advances as for a NOP.
- Outside DECODE, all enables are 0.
- operand is registered from instr_data[10:0] at the DECODE edge and also driven combinationally during DECODE, so it is stable across the whole DECODE cycle.
- cycle_count increments every clock in FETCH or DECODE and holds at 0xFFFF; it does not count while in HALT.

Decomposition:
- Shared package bip_pkg holds:
  - Opcode constants OP_HLT..OP_SUBI.
  - sel_a encodings SEL_A_MEM/SEL_A_IMM/SEL_A_ALU.
  - Field widths.
  - The state enum (FETCH, DECODE, HALT).
- One natural sub-module: bip_decoder, purely combinational. Maps opcode plus a decode-enable input to {sel_a, sel_b, alu_op, wr_acc, wr_ram, rd_ram, illegal, is_halt}.
- The top level keeps the PC, FSM and counter.

Test Plan:
1. Reset then release with program LDI 4 / STO 1 / LDI 2 / LD 1 / ADD 1 / HLT -> pc_addr sequence 0,0,1,1,…,5; in the 4th DECODE rd_ram=1, sel_a=0; halted=1 after PC 5; cycle_count=12 and frozen.
2. Memory returns 0xFFFF at an address -> illegal_op pulses 1 cycle, no enables asserted, pc_addr advances by 1.
3. Program of non-HLT NOP-equivalents filling all 2048 words -> pc_addr wraps 2047->0 and fetch continues.
4. Assert rst low in the middle of an ADD DECODE cycle -> wr_acc drops the same cycle (async); pc_addr=0, cycle_count=0; after release, execution restarts at address 0.
5. SUBI 7 (0x3807) -> sel_a=2, sel_b=1, alu_op=1, wr_acc=1, operand=7 for exactly one cycle.
6. Long loop-free run of more than 65535 cycles (NOP stream) -> cycle_count saturates at 0xFFFF without wrapping.
